// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one 1-cycle-latency synchronous RAM between a CPU and NUM_CH channels.
// Define ARB_ROUND_ROBIN_EN for round-robin channel arbitration; default is fixed priority (lowest index wins).
module ram_arbiter #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CH     = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [ADDR_WIDTH-1:0]        cpu_addr,
    input  logic [DATA_WIDTH-1:0]        cpu_wdata,
    input  logic                         cpu_we,
    input  logic                         cpu_sync,
    output logic                         cpu_ready,
    input  logic [NUM_CH-1:0]            ch_req,
    input  logic [NUM_CH-1:0]            ch_we,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_addr,
    input  logic [NUM_CH*DATA_WIDTH-1:0] ch_wdata,
    output logic [NUM_CH-1:0]            ch_grant,
    output logic [NUM_CH-1:0]            ch_rvalid,
    output logic [ADDR_WIDTH-1:0]        ram_addr,
    output logic [DATA_WIDTH-1:0]        ram_wdata,
    output logic                         ram_we
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {
        CPU_PREP = 2'd0,
        CPU_RUN  = 2'd1,
        CH_OWN   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_cpu_ready;
    logic [NUM_CH-1:0]  r_grant;
    logic [NUM_CH-1:0]  w_grant_nxt;
    logic [NUM_CH-1:0]  r_rvalid;
    logic [IDX_W-1:0]   r_owner;
    logic [IDX_W-1:0]   w_owner_nxt;
    logic [IDX_W-1:0]   w_start;
    logic [IDX_W-1:0]   w_pick;
    logic               w_found;
    logic               w_new_grant;

`ifdef ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0]   r_ptr;
    assign w_start = r_ptr;
`else
    assign w_start = {IDX_W{1'b0}};
`endif

    assign cpu_ready = r_cpu_ready;
    assign ch_grant  = r_grant;
    assign ch_rvalid = r_rvalid;

    // Arbitration: first requesting channel found searching upward from w_start (wrapping).
    always_comb begin
        w_found = 1'b0;
        w_pick  = {IDX_W{1'b0}};
        for (int k = 0; k < NUM_CH; k++) begin
            if (!w_found && ch_req[(int'(w_start) + k) % NUM_CH]) begin
                w_found = 1'b1;
                w_pick  = IDX_W'((int'(w_start) + k) % NUM_CH);
            end else begin
                w_found = w_found;
            end
        end
    end

    // Next-state logic; a released owner hands straight to the next requester without a gap.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_owner_nxt = r_owner;
        w_new_grant = 1'b0;
        case (r_state)
            CPU_PREP: begin
                w_state_nxt = CPU_RUN;
                w_grant_nxt = {NUM_CH{1'b0}};
            end
            CPU_RUN: begin
                if (w_found && cpu_sync) begin
                    w_state_nxt = CH_OWN;
                    w_grant_nxt = NUM_CH'(1'b1) << w_pick;
                    w_owner_nxt = w_pick;
                    w_new_grant = 1'b1;
                end else begin
                    w_state_nxt = CPU_RUN;
                    w_grant_nxt = {NUM_CH{1'b0}};
                end
            end
            CH_OWN: begin
                if (ch_req[r_owner]) begin
                    w_state_nxt = CH_OWN;
                end else if (w_found) begin
                    w_grant_nxt = NUM_CH'(1'b1) << w_pick;
                    w_owner_nxt = w_pick;
                    w_new_grant = 1'b1;
                end else begin
                    w_state_nxt = CPU_PREP;
                    w_grant_nxt = {NUM_CH{1'b0}};
                end
            end
            default: begin
                w_state_nxt = CPU_PREP;
                w_grant_nxt = {NUM_CH{1'b0}};
            end
        endcase
    end

    // State register plus registered ready, grant and read-valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= CPU_PREP;
            r_cpu_ready <= 1'b0;
            r_grant     <= {NUM_CH{1'b0}};
            r_owner     <= {IDX_W{1'b0}};
            r_rvalid    <= {NUM_CH{1'b0}};
        end else begin
            r_state     <= w_state_nxt;
            r_cpu_ready <= (w_state_nxt == CPU_RUN);
            r_grant     <= w_grant_nxt;
            r_owner     <= w_owner_nxt;
            r_rvalid    <= r_grant & ~ch_we;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Round-robin pointer: one past the most recently granted channel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= {IDX_W{1'b0}};
        end else if (w_new_grant) begin
            r_ptr <= IDX_W'((int'(w_pick) + 1) % NUM_CH);
        end else begin
            r_ptr <= r_ptr;
        end
    end
`endif

    // RAM port mux; writes are only possible in CPU_RUN or for a granted channel.
    always_comb begin
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
        ram_we    = 1'b0;
        case (r_state)
            CPU_RUN: begin
                ram_addr  = cpu_addr;
                ram_wdata = cpu_wdata;
                ram_we    = cpu_we;
            end
            CH_OWN: begin
                ram_addr  = ch_addr[r_owner*ADDR_WIDTH +: ADDR_WIDTH];
                ram_wdata = ch_wdata[r_owner*DATA_WIDTH +: DATA_WIDTH];
                ram_we    = ch_we[r_owner];
            end
            default: begin
                ram_addr  = cpu_addr;
                ram_wdata = cpu_wdata;
                ram_we    = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter with a behavioural 1-cycle synchronous RAM.
module tb_ram_arbiter;
    localparam int AW = 11;
    localparam int DW = 8;
    localparam int NC = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic [AW-1:0]     cpu_addr;
    logic [DW-1:0]     cpu_wdata;
    logic              cpu_we;
    logic              cpu_sync;
    logic              cpu_ready;
    logic [NC-1:0]     ch_req;
    logic [NC-1:0]     ch_we;
    logic [NC*AW-1:0]  ch_addr;
    logic [NC*DW-1:0]  ch_wdata;
    logic [NC-1:0]     ch_grant;
    logic [NC-1:0]     ch_rvalid;
    logic [AW-1:0]     ram_addr;
    logic [DW-1:0]     ram_wdata;
    logic              ram_we;

    logic [DW-1:0]     mem [0:(1<<AW)-1];
    logic [DW-1:0]     ram_dout;

    int n_checks = 0;
    int n_fail   = 0;

    ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CH(NC)) dut (
        .clk(clk), .reset(reset),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_sync(cpu_sync),
        .cpu_ready(cpu_ready),
        .ch_req(ch_req), .ch_we(ch_we), .ch_addr(ch_addr), .ch_wdata(ch_wdata),
        .ch_grant(ch_grant), .ch_rvalid(ch_rvalid),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we)
    );

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_dout <= mem[ram_addr];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_reset();
        cpu_addr = 11'h055; cpu_we = 1'b1; cpu_wdata = 8'h11;
        step();
        n_checks++; if (cpu_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", cpu_ready); end
        n_checks++; if (ch_grant !== 2'b00) begin n_fail++; $display("FAIL rst_grant: got %b want 00", ch_grant); end
        n_checks++; if (ch_rvalid !== 2'b00) begin n_fail++; $display("FAIL rst_rvalid: got %b want 00", ch_rvalid); end
        n_checks++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL rst_ram_we: got %b want 0", ram_we); end
        n_checks++; if (ram_addr !== 11'h055) begin n_fail++; $display("FAIL rst_ram_addr: got %h want 055", ram_addr); end
        reset = 1'b0;
        #1;
        n_checks++; if (cpu_ready !== 1'b0) begin n_fail++; $display("FAIL rel_c1_ready: got %b want 0", cpu_ready); end
        n_checks++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL rel_c1_ram_we: got %b want 0", ram_we); end
        step();
        n_checks++; if (cpu_ready !== 1'b1) begin n_fail++; $display("FAIL rel_c2_ready: got %b want 1", cpu_ready); end
        n_checks++; if (ram_we !== 1'b1) begin n_fail++; $display("FAIL rel_c2_ram_we: got %b want 1", ram_we); end
        step();
        n_checks++; if (cpu_ready !== 1'b1) begin n_fail++; $display("FAIL rel_c3_ready: got %b want 1", cpu_ready); end
        cpu_we = 1'b0;
    endtask

    task automatic test_sync_wait();
        ch_req = 2'b01; cpu_sync = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++; if (ch_grant !== 2'b00 || cpu_ready !== 1'b1) begin n_fail++; $display("FAIL nosync_hold%0d: got grant=%b ready=%b want 00/1", i, ch_grant, cpu_ready); end
        end
        cpu_sync = 1'b1;
        step();
        cpu_sync = 1'b0;
        n_checks++; if (ch_grant !== 2'b01) begin n_fail++; $display("FAIL sync_grant: got %b want 01", ch_grant); end
        n_checks++; if (cpu_ready !== 1'b0) begin n_fail++; $display("FAIL sync_ready: got %b want 0", cpu_ready); end
    endtask

    task automatic test_ch_write();
        cpu_addr = 11'h010; cpu_wdata = 8'h5A; cpu_we = 1'b1;
        ch_we = 2'b01; ch_addr[AW-1:0] = 11'h123; ch_wdata[DW-1:0] = 8'hA5;
        #1;
        n_checks++; if (ram_we !== 1'b1 || ram_addr !== 11'h123 || ram_wdata !== 8'hA5) begin n_fail++; $display("FAIL ch0_wr_port: got we=%b a=%h d=%h want 1/123/a5", ram_we, ram_addr, ram_wdata); end
        step();
        ch_req = 2'b00; ch_we = 2'b00;
        step();
        n_checks++; if (ch_grant !== 2'b00 || cpu_ready !== 1'b0) begin n_fail++; $display("FAIL prep_after_drop: got grant=%b ready=%b want 00/0", ch_grant, cpu_ready); end
        n_checks++; if (ram_we !== 1'b0 || ram_addr !== 11'h010) begin n_fail++; $display("FAIL prep_ram: got we=%b a=%h want 0/010", ram_we, ram_addr); end
        step();
        n_checks++; if (cpu_ready !== 1'b1 || ram_we !== 1'b1) begin n_fail++; $display("FAIL run_after_prep: got ready=%b we=%b want 1/1", cpu_ready, ram_we); end
        step();
        cpu_we = 1'b0;
        n_checks++; if (mem[11'h123] !== 8'hA5) begin n_fail++; $display("FAIL ram_123: got %h want a5", mem[11'h123]); end
        n_checks++; if (mem[11'h010] !== 8'h5A) begin n_fail++; $display("FAIL ram_010: got %h want 5a", mem[11'h010]); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        ch_addr = {11'h010, 11'h123}; ch_we = 2'b00; ch_req = 2'b11; cpu_sync = 1'b1;
        step();
        cpu_sync = 1'b0;
        n_checks++; if (ch_grant !== 2'b01 || ch_rvalid !== 2'b00) begin n_fail++; $display("FAIL b2b_c1: got grant=%b rvalid=%b want 01/00", ch_grant, ch_rvalid); end
        step();
        n_checks++; if (ch_grant !== 2'b01 || ch_rvalid !== 2'b01) begin n_fail++; $display("FAIL b2b_c2: got grant=%b rvalid=%b want 01/01", ch_grant, ch_rvalid); end
        n_checks++; if (ram_dout !== 8'hA5) begin n_fail++; $display("FAIL b2b_rd0: got %h want a5", ram_dout); end
        step();
        n_checks++; if (ch_grant !== 2'b01) begin n_fail++; $display("FAIL b2b_c3: got %b want 01", ch_grant); end
        ch_req = 2'b10;
        step();
        n_checks++; if (ch_grant !== 2'b10 || ch_rvalid !== 2'b01 || cpu_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_handoff: got grant=%b rvalid=%b ready=%b want 10/01/0", ch_grant, ch_rvalid, cpu_ready); end
        step();
        n_checks++; if (ch_grant !== 2'b10 || ch_rvalid !== 2'b10) begin n_fail++; $display("FAIL b2b_c5: got grant=%b rvalid=%b want 10/10", ch_grant, ch_rvalid); end
        n_checks++; if (ram_dout !== 8'h5A) begin n_fail++; $display("FAIL b2b_rd1: got %h want 5a", ram_dout); end
        ch_req = 2'b00;
        step();
        n_checks++; if (ch_grant !== 2'b00 || ch_rvalid !== 2'b10 || cpu_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_prep: got grant=%b rvalid=%b ready=%b want 00/10/0", ch_grant, ch_rvalid, cpu_ready); end
        step();
        n_checks++; if (cpu_ready !== 1'b1 || ch_rvalid !== 2'b00) begin n_fail++; $display("FAIL b2b_run: got ready=%b rvalid=%b want 1/00", cpu_ready, ch_rvalid); end
    endtask

    task automatic test_rr();
        logic [1:0] exp_g [3];
`ifdef ARB_ROUND_ROBIN_EN
        exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01;
`else
        exp_g[0] = 2'b01; exp_g[1] = 2'b01; exp_g[2] = 2'b01;
`endif
        for (int e = 0; e < 3; e++) begin
            ch_req = 2'b11; cpu_sync = 1'b1;
            step();
            ch_req = 2'b00; cpu_sync = 1'b0;
            n_checks++; if (ch_grant !== exp_g[e]) begin n_fail++; $display("FAIL rr_ep%0d: got %b want %b", e, ch_grant, exp_g[e]); end
            step();
            step();
            n_checks++; if (cpu_ready !== 1'b1) begin n_fail++; $display("FAIL rr_cpu_gap%0d: got %b want 1", e, cpu_ready); end
        end
    endtask

    task automatic test_reset_mid();
        cpu_addr = 11'h077; cpu_we = 1'b0;
        ch_addr[AW-1:0] = 11'h200; ch_we = 2'b00; ch_req = 2'b01; cpu_sync = 1'b1;
        step();
        cpu_sync = 1'b0;
        step();
        n_checks++; if (ch_grant !== 2'b01 || ch_rvalid !== 2'b01) begin n_fail++; $display("FAIL mid_pre: got grant=%b rvalid=%b want 01/01", ch_grant, ch_rvalid); end
        ch_we = 2'b01;
        #1;
        n_checks++; if (ram_we !== 1'b1) begin n_fail++; $display("FAIL mid_pre_we: got %b want 1", ram_we); end
        #1;
        reset = 1'b1;
        #1;
        n_checks++; if (ch_grant !== 2'b00 || cpu_ready !== 1'b0 || ch_rvalid !== 2'b00) begin n_fail++; $display("FAIL mid_async: got grant=%b ready=%b rvalid=%b want 00/0/00", ch_grant, cpu_ready, ch_rvalid); end
        n_checks++; if (ram_we !== 1'b0 || ram_addr !== 11'h077) begin n_fail++; $display("FAIL mid_ram: got we=%b a=%h want 0/077", ram_we, ram_addr); end
        step();
        reset = 1'b0; ch_req = 2'b00; ch_we = 2'b00;
        #1;
        n_checks++; if (cpu_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rel_c1: got %b want 0", cpu_ready); end
        step();
        n_checks++; if (cpu_ready !== 1'b1 || ch_grant !== 2'b00) begin n_fail++; $display("FAIL mid_rel_c2: got ready=%b grant=%b want 1/00", cpu_ready, ch_grant); end
    endtask

    initial begin
        reset = 1'b1; cpu_addr = '0; cpu_wdata = '0; cpu_we = 1'b0; cpu_sync = 1'b0;
        ch_req = '0; ch_we = '0; ch_addr = '0; ch_wdata = '0;
        test_reset();
        test_sync_wait();
        test_ch_write();
        test_back_to_back();
        test_rr();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 11, RAM address width.
REQ-002 Parameter DATA_WIDTH, default 8, RAM data width.
REQ-003 Parameter NUM_CH, default 2, number of non-CPU channels, range 1..8.
REQ-004 clk  in  1  single clock for the whole block.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 cpu_addr / cpu_wdata / cpu_we  in  ADDR_WIDTH / DATA_WIDTH / 1  CPU memory request.
REQ-007 cpu_sync  in  1  CPU is starting a new instruction.
REQ-008 cpu_ready  out  1  registered RDY to CPU.
REQ-009 ch_req / ch_we  in  NUM_CH / NUM_CH  per-channel request and write enable.
REQ-010 ch_addr / ch_wdata  in  NUM_CH*ADDR_WIDTH / NUM_CH*DATA_WIDTH  flattened buses, channel i at slice i.
REQ-011 ch_grant / ch_rvalid  out  NUM_CH / NUM_CH  one-hot grant; read data valid on RAM dout.
REQ-012 ram_addr / ram_wdata / ram_we  out  ADDR_WIDTH / DATA_WIDTH / 1  to a 1-cycle-latency synchronous RAM.

Function
REQ-013 The FSM SHALL have states CPU_PREP, CPU_RUN, CH_OWN.
REQ-014 CPU_PREP: cpu_ready=0, ram_addr=cpu_addr, ram_we=0; after exactly one cycle the FSM SHALL enter CPU_RUN regardless of ch_req.
REQ-015 CPU_RUN: cpu_ready=1, ram_addr/ram_wdata driven from the CPU, ram_we=cpu_we.
REQ-016 In CPU_RUN, if any ch_req bit is 1 AND cpu_sync=1 in the same cycle, the FSM SHALL enter CH_OWN next cycle for the arbitrated channel; if cpu_sync=0, it SHALL stay in CPU_RUN.
REQ-017 CH_OWN: cpu_ready=0, ch_grant one-hot for owner g, RAM driven from channel g, ram_we=ch_we[g].
REQ-018 The owner SHALL keep its grant while ch_req[g]=1; no preemption.
REQ-019 When ch_req[g]=0 in CH_OWN: if other requests are pending, the next owner SHALL be granted on the following cycle with no gap; otherwise the FSM SHALL enter CPU_PREP.
REQ-020 Arbitration SHALL sample ch_req only in the decision cycle; a request withdrawn before that cycle SHALL not be granted.
REQ-021 ch_rvalid[i] SHALL be registered and equal ch_grant[i] & ~ch_we[i] from the previous cycle.
REQ-022 The CPU SHALL get at least one cycle with cpu_ready=1 between any two CH_OWN periods, which guarantees forward progress.
REQ-023 Default arbitration SHALL be fixed priority, with the lowest index winning.
REQ-024 ram_we SHALL never be 1 while cpu_ready=0 unless a channel is granted.

Reset
REQ-025 Reset assertion SHALL immediately force state=CPU_PREP, cpu_ready=0, ch_grant=0, ch_rvalid=0, and the round-robin pointer to 0, even mid-transfer.
REQ-026 While reset is high, ram_we SHALL be 0 and ram_addr SHALL be cpu_addr.
REQ-027 The first cycle after release SHALL be CPU_PREP, and the second SHALL be CPU_RUN.

Configuration
REQ-028 Macro ARB_ROUND_ROBIN_EN defined: the search SHALL start at index (last owner+1) mod NUM_CH, with the pointer updated on each grant.
REQ-029 Macro ARB_ROUND_ROBIN_EN undefined: fixed priority per REQ-023; no pointer register exists.

Verification
REQ-030 After reset release with no ch_req: cpu_ready=0 at cycle 1, then 1 from cycle 2 onward; ram_we follows cpu_we only from cycle 2.
REQ-031 In CPU_RUN, ch_req=01 with cpu_sync=0 for 5 cycles, then 1: grant=01 exactly one cycle after sync; cpu_ready=0 the same cycle.
REQ-032 Channel 0 writes 0xA5 at 0x123, then drops req: RAM[0x123]=0xA5; CPU_PREP for one cycle; cpu_ready=1 the next cycle.
REQ-033 ch_req=11 at the decision point, with ch0 holding 3 cycles: grant=01 for 3 cycles, then 10 with no gap; ch_rvalid on reads lags grant by one cycle.
REQ-034 ARB_ROUND_ROBIN_EN defined, ch_req=11 repeatedly: grants alternate ch0, ch1, ch0 across episodes; undefined: ch0 always first.
REQ-035 Reset asserted mid-CH_OWN: ch_grant=0 and cpu_ready=0 immediately, without waiting for a clock edge; recovery follows REQ-027.
